// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the cache line RAM.
package cache_pkg;

   localparam int unsigned CACHE_LW  = 256;
   localparam int unsigned CACHE_NL  = 256;
   localparam int unsigned CACHE_LSS = 8;

   typedef enum logic {
      SWEEP = 1'b0,
      IDLE  = 1'b1
   } cache_state_e;

endpackage

// File: rtl/cache_ram2p_array.sv
// Behavioural NL x LW storage: one synchronous read-first port, one byte-lane write port.
module cache_ram2p_array
   import cache_pkg::*;
#(
   parameter int unsigned LW  = CACHE_LW,
   parameter int unsigned NL  = CACHE_NL,
   parameter int unsigned LSS = CACHE_LSS,
   localparam int unsigned NB = LW / 8
) (
   input  logic           clk_i,
   input  logic           re_i,
   input  logic [LSS-1:0] raddr_i,
   output logic [LW-1:0]  rdata_o,
   input  logic [NB-1:0]  we_i,
   input  logic [LSS-1:0] waddr_i,
   input  logic [LW-1:0]  wdata_i
);

   logic [LW-1:0] mem_q [NL];
   logic [LW-1:0] rdata_q;

   // Read samples the array before this edge's write lands (read-first).
   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
      for (int unsigned i = 0; i < NB; i++) begin
         if (we_i[i]) begin
            mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_ram2p.sv
// 1R1W cache line RAM with byte-lane writes, same-cycle read/write forwarding,
// per-line valid bits and a zero-fill sweep after reset or an invalidate request.
module cache_ram2p
   import cache_pkg::*;
#(
   parameter int unsigned LW  = CACHE_LW,
   parameter int unsigned NL  = CACHE_NL,
   parameter int unsigned LSS = CACHE_LSS,
   localparam int unsigned NB = LW / 8
) (
   input  logic           nGCLK,
   input  logic           RESET,
   input  logic           rd_ena,
   input  logic [LSS-1:0] read_sel,
   output logic [LW-1:0]  read_port,
   output logic           read_valid,
   input  logic           wr_ena,
   input  logic [LSS-1:0] write_sel,
   input  logic [LW-1:0]  write_port,
   input  logic [NB-1:0]  byte_ena,
   input  logic           inval_req,
   output logic           busy
);

   cache_state_e   state_q, state_d;
   logic [LSS-1:0] swp_cnt_q, swp_cnt_d;
   logic [NL-1:0]  valid_q, valid_d;

   logic           rd_acc;
   logic           fwd_hit;
   logic           rd_zero_q;
   logic           read_valid_q;
   logic [NB-1:0]  fwd_be_q;
   logic [LW-1:0]  fwd_data_q;

   logic [LW-1:0]  arr_rdata;
   logic [LW-1:0]  arr_wdata;
   logic [NB-1:0]  arr_we;
   logic [LSS-1:0] arr_waddr;

   assign rd_acc  = (state_q == IDLE) && rd_ena && !RESET;
   assign fwd_hit = wr_ena && (read_sel == write_sel);

   always_ff @(posedge nGCLK) begin
      if (RESET) begin
         state_q   <= SWEEP;
         swp_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         swp_cnt_q <= swp_cnt_d;
      end
   end

   // Valid bits need no reset: the sweep that follows reset clears every one.
   always_ff @(posedge nGCLK) begin
      if (!RESET) begin
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      swp_cnt_d = swp_cnt_q;
      valid_d   = valid_q;
      unique case (state_q)
         SWEEP: begin
            swp_cnt_d          = swp_cnt_q + 1'b1;
            valid_d[swp_cnt_q] = 1'b0;
            if (swp_cnt_q == LSS'(NL - 1)) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (wr_ena) begin
               valid_d[write_sel] = 1'b1;
            end
            if (inval_req) begin
               state_d = SWEEP;
            end
         end
      endcase
   end

   always_comb begin
      busy      = (state_q == SWEEP);
      arr_we    = '0;
      arr_waddr = write_sel;
      arr_wdata = write_port;
      if (!RESET) begin
         unique case (state_q)
            SWEEP: begin
               arr_we    = '1;
               arr_waddr = swp_cnt_q;
               arr_wdata = '0;
            end
            IDLE: begin
               if (wr_ena) begin
                  arr_we = byte_ena;
               end
            end
         endcase
      end
   end

   // The array returns the pre-write line; lanes written in the same cycle are patched in here.
   always_ff @(posedge nGCLK) begin
      if (RESET) begin
         rd_zero_q    <= 1'b1;
         read_valid_q <= 1'b0;
         fwd_be_q     <= '0;
      end else if (rd_acc) begin
         rd_zero_q    <= 1'b0;
         read_valid_q <= fwd_hit | valid_q[read_sel];
         fwd_be_q     <= fwd_hit ? byte_ena : '0;
      end
   end

   always_ff @(posedge nGCLK) begin
      if (rd_acc && fwd_hit) begin
         fwd_data_q <= write_port;
      end
   end

   always_comb begin
      read_port = arr_rdata;
      for (int unsigned i = 0; i < NB; i++) begin
         if (fwd_be_q[i]) begin
            read_port[8*i +: 8] = fwd_data_q[8*i +: 8];
         end
      end
      if (rd_zero_q) begin
         read_port = '0;
      end
   end

   assign read_valid = read_valid_q;

   cache_ram2p_array #(
      .LW  (LW),
      .NL  (NL),
      .LSS (LSS)
   ) u_array (
      .clk_i   (nGCLK),
      .re_i    (rd_acc),
      .raddr_i (read_sel),
      .rdata_o (arr_rdata),
      .we_i    (arr_we),
      .waddr_i (arr_waddr),
      .wdata_i (arr_wdata)
   );

endmodule
